// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- fetch-stage program counter with debug execution control
//
// Holds the current PC, supplies PC+4 to the next-PC multiplexer, and gates PC
// updates through a small IDLE/RUN/STEP/HALTED controller. The controller is
// driven by the debug unit (run, step, clear), the hazard unit (stall) and the
// decoder (halt). A saturating counter records cycles spent in RUN or STEP.
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   Adds o_misaligned. A misaligned next PC (low two bits non-zero) is not
//   loaded. Instead the unit enters HALTED and sets o_misaligned, which stays
//   set until i_clear or reset. Without the macro, i_next_pc is loaded
//   unmodified, including its low bits.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_next_pc    next PC from the next-PC multiplexer
//   i_stall      hazard stall; the PC holds while high
//   i_halt       HALT instruction decoded in fetch
//   i_run        debug: enter continuous execution
//   i_step       debug: execute one instruction (one-cycle pulse)
//   i_clear      debug: go to IDLE, PC = RESET_PC, clear the counter
//   o_pc         current PC to instruction memory
//   o_pc4        o_pc + 4, modulo 2^NB
//   o_advance    high in cycles where the PC loads i_next_pc
//   o_step_done  one-cycle pulse after a single step completes
//   o_halted     high while in HALTED
//   o_cycle_cnt  saturating count of cycles spent in RUN or STEP
//   o_misaligned (PC_ALIGN_CHECK_EN only) sticky misaligned-PC flag
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int          NB       = 32,
    parameter logic [NB-1:0] RESET_PC = '0,
    parameter int          NB_CNT   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NB-1:0]     i_next_pc,
    input  logic              i_stall,
    input  logic              i_halt,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_clear,
    output logic [NB-1:0]     o_pc,
    output logic [NB-1:0]     o_pc4,
    output logic              o_advance,
    output logic              o_step_done,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_cycle_cnt
`ifdef PC_ALIGN_CHECK_EN
   ,output logic              o_misaligned
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state;
    logic   executing;
    logic   misalign_hit;

    // Wraps modulo 2^NB; the carry out is intentionally dropped.
    assign o_pc4 = o_pc + NB'(4);

    // o_advance depends only on state, stall and halt, so i_next_pc never
    // reaches an output combinationally.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        executing = 1'b0;
        o_advance = 1'b0;
        if (state == RUN || state == STEP) begin
            executing = 1'b1;
            o_advance = !i_stall && !i_halt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // An advance with a misaligned target becomes a halt, not a load.
    assign misalign_hit = o_advance && (i_next_pc[1:0] != 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_misaligned <= 1'b0;
        end else if (i_clear) begin
            o_misaligned <= 1'b0;
        end else if (misalign_hit) begin
            o_misaligned <= 1'b1;
        end
    end
`else
    assign misalign_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the clock edge regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_pc        <= RESET_PC;
            o_cycle_cnt <= '0;
            o_step_done <= 1'b0;
            o_halted    <= 1'b0;
        end else if (i_clear) begin
            // Clear outranks everything, including a simultaneous step.
            state       <= IDLE;
            o_pc        <= RESET_PC;
            o_cycle_cnt <= '0;
            o_step_done <= 1'b0;
            o_halted    <= 1'b0;
        end else begin
            o_step_done <= 1'b0;

            // Stalled RUN/STEP cycles count as well; saturate at all-ones.
            if (executing && o_cycle_cnt != '1) begin
                o_cycle_cnt <= o_cycle_cnt + NB_CNT'(1);
            end

            unique case (state)
                IDLE: begin
                    if (i_run) begin
                        state <= RUN;
                    end else if (i_step) begin
                        state <= STEP;
                    end
                end
                RUN: begin
                    // A halt freezes the PC even while stalled.
                    if (i_halt || misalign_hit) begin
                        state    <= HALTED;
                        o_halted <= 1'b1;
                    end else if (o_advance) begin
                        o_pc <= i_next_pc;
                    end
                end
                STEP: begin
                    if (i_halt || misalign_hit) begin
                        state    <= HALTED;
                        o_halted <= 1'b1;
                    end else if (o_advance) begin
                        o_pc        <= i_next_pc;
                        state       <= IDLE;
                        o_step_done <= 1'b1;
                    end
                end
                HALTED: begin
                    // Only i_clear, handled above, leaves this state.
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- scoreboard bench for pc_unit
//
// A driver applies directed and random stimulus on the falling edge. It
// predicts the outputs for that cycle from a behavioural model and queues the
// prediction. A separate monitor pops and compares each cycle. The counter is
// built 6 bits wide so that saturation is reached during the random phase.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam int NB      = 32;
    localparam int NB_CNT  = 6;
    localparam int CNT_MAX = (1 << NB_CNT) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB-1:0]     next_pc;
    logic              stall, halt, run, step, clear;
    logic [NB-1:0]     pc, pc4;
    logic              advance, step_done, halted;
    logic [NB_CNT-1:0] cycle_cnt;
`ifdef PC_ALIGN_CHECK_EN
    logic              misaligned;
`endif

    pc_unit #(.NB(NB), .RESET_PC('0), .NB_CNT(NB_CNT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_next_pc(next_pc), .i_stall(stall),
        .i_halt(halt), .i_run(run), .i_step(step), .i_clear(clear),
        .o_pc(pc), .o_pc4(pc4), .o_advance(advance), .o_step_done(step_done),
        .o_halted(halted), .o_cycle_cnt(cycle_cnt)
`ifdef PC_ALIGN_CHECK_EN
       ,.o_misaligned(misaligned)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode flags: running / stepping / frozen. All clear means idle.
    bit          m_running, m_stepping, m_frozen, m_done, m_mis;
    logic [31:0] m_pc;
    int          m_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        adv;
        logic        done;
        logic        halted;
        int          cnt;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    task automatic model_reset();
        m_running = 0; m_stepping = 0; m_frozen = 0; m_done = 0; m_mis = 0;
        m_pc = 32'h0; m_cnt = 0;
    endtask

    // One cycle: set inputs, queue the prediction, then advance the model.
    task automatic drive(input bit r, input bit s, input bit st, input bit h,
                         input bit c, input logic [31:0] np);
        exp_t e;
        bit   busy, moves;
        @(negedge clk);
        run = r; step = s; stall = st; halt = h; clear = c; next_pc = np;
        #1;
        busy  = m_running || m_stepping;
        moves = busy && !st && !h;
        e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.adv = moves; e.done = m_done;
        e.halted = m_frozen; e.cnt = m_cnt; e.mis = m_mis;
        exp_q.push_back(e);

        if (c) begin
            model_reset();
        end else begin
            m_done = 0;
            if (busy) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (busy) begin
`ifdef PC_ALIGN_CHECK_EN
                if (moves && np[1:0] != 2'b00) begin
                    m_mis = 1;
                    m_frozen = 1; m_running = 0; m_stepping = 0;
                end else
`endif
                if (h) begin
                    m_frozen = 1; m_running = 0; m_stepping = 0;
                end else if (!st) begin
                    m_pc = np;
                    if (m_stepping) begin
                        m_stepping = 0;
                        m_done = 1;
                    end
                end
            end else if (!m_frozen) begin
                if (r) m_running = 1;
                else if (s) m_stepping = 1;
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",        pc,        e.pc);
                check("pc4",       pc4,       e.pc4);
                check("advance",   advance,   e.adv);
                check("step_done", step_done, e.done);
                check("halted",    halted,    e.halted);
                check("cycle_cnt", cycle_cnt, e.cnt);
`ifdef PC_ALIGN_CHECK_EN
                check("misaligned", misaligned, e.mis);
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rand_next();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)       rand_next = m_pc + 32'd4;
        else if (sel == 6) rand_next = 32'hFFFF_FFFC;
        else if (sel == 7) rand_next = $urandom() & 32'hFFFF_FFFC;
        else               rand_next = $urandom();
        return rand_next;
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 39) == 0, rand_next());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run = 0; step = 0; stall = 0; halt = 0; clear = 0; next_pc = '0;
        model_reset();
        #17;
        rst_n = 1'b1;

        // 1. reset values
        drive(0, 0, 0, 0, 0, 32'h0);
        check("reset_pc4", pc4, 32'd4);
        check("reset_cnt", cycle_cnt, 0);

        // 2. run, four sequential advances
        drive(1, 0, 0, 0, 0, m_pc + 4);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, m_pc + 4);
        drive(0, 0, 1, 0, 0, m_pc + 4);
        check("run4_pc", pc, 32'd16);
        check("run4_cnt", cycle_cnt, 4);
        drive(0, 0, 0, 0, 1, m_pc + 4);

        // 3. stall two cycles at PC 8, then resume to 12
        drive(1, 0, 0, 0, 0, m_pc + 4);
        drive(0, 0, 0, 0, 0, m_pc + 4);
        drive(0, 0, 0, 0, 0, m_pc + 4);
        drive(0, 0, 1, 0, 0, m_pc + 4);
        drive(0, 0, 1, 0, 0, m_pc + 4);
        drive(0, 0, 0, 0, 0, m_pc + 4);
        drive(0, 0, 1, 0, 0, m_pc + 4);
        check("stall_resume_pc", pc, 32'd12);
        check("stall_cnt", cycle_cnt, 5);
        drive(0, 0, 0, 0, 1, 32'h0);

        // 4. step with one stalled cycle, target 0x40
        drive(0, 1, 0, 0, 0, 32'h40);
        drive(0, 0, 1, 0, 0, 32'h40);
        drive(0, 0, 0, 0, 0, 32'h40);
        drive(0, 0, 0, 0, 0, 32'h80);
        check("step_pc", pc, 32'h40);
        check("step_done_pulse", step_done, 1'b1);
        drive(0, 0, 0, 0, 0, 32'h80);
        check("step_idle", pc, 32'h40);
        drive(0, 0, 0, 0, 1, 32'h0);

        // 5. halt with stall at 0x20, run ignored, clear recovers
        drive(1, 0, 0, 0, 0, 32'h20);
        drive(0, 0, 0, 0, 0, 32'h20);
        drive(1, 0, 1, 1, 0, 32'h24);
        drive(1, 0, 0, 0, 0, 32'h24);
        drive(1, 1, 0, 0, 0, 32'h24);
        check("halt_pc", pc, 32'h20);
        check("halt_flag", halted, 1'b1);
        drive(0, 0, 0, 0, 1, 32'h24);
        drive(0, 0, 0, 0, 0, 32'h24);
        check("clear_pc", pc, 32'h0);
        check("clear_halted", halted, 1'b0);

`ifdef PC_ALIGN_CHECK_EN
        // 6. misaligned target halts instead of loading
        drive(1, 0, 0, 0, 0, 32'h4);
        drive(0, 0, 0, 0, 0, 32'h4);
        drive(0, 0, 0, 0, 0, 32'h6);
        drive(0, 0, 0, 0, 0, 32'h8);
        check("mis_pc", pc, 32'h4);
        check("mis_flag", misaligned, 1'b1);
        drive(0, 0, 0, 0, 1, 32'h0);
`endif

        // Simultaneous step and clear: clear wins, stays idle.
        drive(0, 1, 0, 0, 1, 32'h100);
        drive(0, 0, 0, 0, 0, 32'h100);

        random_phase(1500);

        // Asynchronous reset in the middle of RUN.
        drive(0, 0, 0, 0, 1, 32'h0);
        drive(1, 0, 0, 0, 0, 32'h8);
        drive(0, 0, 0, 0, 0, 32'h10);
        drive(0, 0, 0, 0, 0, 32'h20);
        #2;
        rst_n = 1'b0;
        run = 0; step = 0; stall = 0; halt = 0; clear = 0;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_cnt", cycle_cnt, 0);
        check("async_rst_adv", advance, 1'b0);
        model_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        random_phase(1500);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
